// File: rtl/fml_bram_if.sv
// FML 4x64 burst bus: one initiator (master) and one target (slave).
interface fml_bram_if #(
   parameter int fml_depth = 26
);
   logic [fml_depth-1:0] fml_adr;
   logic                 fml_stb;
   logic                 fml_we;
   logic                 fml_ack;
   logic [7:0]           fml_sel;
   logic [63:0]          fml_do;
   logic [63:0]          fml_di;

   modport master (output fml_adr, fml_stb, fml_we, fml_sel, fml_do,
                   input  fml_ack, fml_di);
   modport slave  (input  fml_adr, fml_stb, fml_we, fml_sel, fml_do,
                   output fml_ack, fml_di);
endinterface

// File: rtl/fml_bram_target.sv
// FML 4x64 target backed by block RAM, with CSR burst counters and write-protect.
module fml_bram_target #(
   parameter logic [4:0] csr_addr    = 5'h0,
   parameter int         fml_depth   = 26,
   parameter int         burst_bits  = 10,
   parameter int         wait_cycles = 0
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [14:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do,
   fml_bram_if.slave   fml
);
   localparam int         AW        = burst_bits + 2;
   localparam int         WAIT_LAST = (wait_cycles > 0) ? wait_cycles - 1 : 0;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_LAST);

   typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

   state_t                state_q, state_d;
   logic [burst_bits-1:0] index_q, index_d;
   logic                  we_q, we_d;
   logic [1:0]            beat_q, beat_d;
   logic [3:0]            wait_q, wait_d;
   logic                  ack_q, ack_d;
   logic [63:0]           di_q, di_d;
   logic [31:0]           csr_do_q, csr_do_d;
   logic [31:0]           read_count_q, read_count_d;
   logic [31:0]           write_count_q, write_count_d;
   logic                  wp_q, wp_d;

   logic [63:0]           mem [0:(1<<AW)-1];
   logic [AW-1:0]         rd_addr;
   logic [AW-1:0]         wr_addr;
   logic                  ram_load;
   logic                  ram_we;
   logic                  csr_sel;

   logic [fml_depth-1:0]  unused_adr;
   logic                  unused_csr;
   assign unused_adr = fml.fml_adr;
   assign unused_csr = ^{csr_a[9:3], csr_di[31:1]};

   // fml_di is loaded only on edges that enter a read beat, so it holds between bursts.
   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      we_d     = we_q;
      beat_d   = beat_q;
      wait_d   = wait_q;
      ack_d    = 1'b0;
      ram_load = 1'b0;
      rd_addr  = {index_q, beat_q + 2'd1};
      case (state_q)
         IDLE: begin
            rd_addr = {fml.fml_adr[burst_bits+4:5], 2'b00};
            if (fml.fml_stb) begin
               index_d = fml.fml_adr[burst_bits+4:5];
               we_d    = fml.fml_we;
               beat_d  = 2'd0;
               if (wait_cycles > 0) begin
                  state_d = WAIT;
                  wait_d  = WAIT_INIT;
               end else begin
                  state_d  = XFER;
                  ack_d    = 1'b1;
                  ram_load = !fml.fml_we;
               end
            end
         end
         WAIT: begin
            rd_addr = {index_q, 2'b00};
            if (wait_q == 4'd0) begin
               state_d  = XFER;
               ack_d    = 1'b1;
               ram_load = !we_q;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         XFER: begin
            beat_d   = beat_q + 2'd1;
            ram_load = !we_q && (beat_q != 2'd3);
            if (beat_q == 2'd3) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      di_d = ram_load ? mem[rd_addr] : di_q;
   end

   // CSR clear takes priority over a same-cycle counter increment.
   always_comb begin
      csr_sel       = (csr_a[14:10] == csr_addr);
      read_count_d  = read_count_q;
      write_count_d = write_count_q;
      wp_d          = wp_q;
      csr_do_d      = 32'd0;
      if (ack_q && !we_q) read_count_d  = read_count_q + 32'd1;
      if (ack_q && we_q)  write_count_d = write_count_q + 32'd1;
      if (csr_sel && csr_we) begin
         case (csr_a[2:0])
            3'd0:    read_count_d  = 32'd0;
            3'd1:    write_count_d = 32'd0;
            3'd2:    wp_d          = csr_di[0];
            default: ;
         endcase
      end
      if (csr_sel) begin
         case (csr_a[2:0])
            3'd0:    csr_do_d = read_count_q;
            3'd1:    csr_do_d = write_count_q;
            3'd2:    csr_do_d = {31'd0, wp_q};
            default: csr_do_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= IDLE;
         index_q       <= '0;
         we_q          <= 1'b0;
         beat_q        <= 2'd0;
         wait_q        <= 4'd0;
         ack_q         <= 1'b0;
         di_q          <= 64'd0;
         csr_do_q      <= 32'd0;
         read_count_q  <= 32'd0;
         write_count_q <= 32'd0;
         wp_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         index_q       <= index_d;
         we_q          <= we_d;
         beat_q        <= beat_d;
         wait_q        <= wait_d;
         ack_q         <= ack_d;
         di_q          <= di_d;
         csr_do_q      <= csr_do_d;
         read_count_q  <= read_count_d;
         write_count_q <= write_count_d;
         wp_q          <= wp_d;
      end
   end

   // Write port; an asynchronous reset drops state_q to IDLE, so no later beat lands.
   assign ram_we  = (state_q == XFER) && we_q && !wp_q;
   assign wr_addr = {index_q, beat_q};

   always_ff @(posedge sys_clk) begin
      if (ram_we) begin
         for (int b = 0; b < 8; b++) begin
            if (fml.fml_sel[b]) mem[wr_addr][b*8 +: 8] <= fml.fml_do[b*8 +: 8];
         end
      end
   end

   assign fml.fml_ack = ack_q;
   assign fml.fml_di  = di_q;
   assign csr_do      = csr_do_q;
endmodule

// File: tb/tb_fml_bram_target.sv
// Scoreboard bench for fml_bram_target: a zero-wait and a three-wait target on one CSR bus.
module tb_fml_bram_target;
   localparam int BB0 = 10;
   localparam int BB1 = 4;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [14:0] csr_a     = '0;
   logic        csr_we    = 1'b0;
   logic [31:0] csr_di    = '0;
   logic [31:0] csr_do0, csr_do1;
   logic [25:0] adr  = '0;
   logic        we   = 1'b0;
   logic [7:0]  sel  = '0;
   logic [63:0] wdat = '0;
   logic [1:0]  stb  = '0;
   logic [1:0]        ack_w;
   logic [1:0][63:0]  di_w;

   fml_bram_if #(.fml_depth(26)) if0 ();
   fml_bram_if #(.fml_depth(26)) if1 ();

   assign if0.fml_adr = adr;  assign if1.fml_adr = adr;
   assign if0.fml_we  = we;   assign if1.fml_we  = we;
   assign if0.fml_sel = sel;  assign if1.fml_sel = sel;
   assign if0.fml_do  = wdat; assign if1.fml_do  = wdat;
   assign if0.fml_stb = stb[0];
   assign if1.fml_stb = stb[1];
   assign ack_w[0] = if0.fml_ack;
   assign ack_w[1] = if1.fml_ack;
   assign di_w[0]  = if0.fml_di;
   assign di_w[1]  = if1.fml_di;

   fml_bram_target #(.csr_addr(5'h0), .fml_depth(26), .burst_bits(BB0), .wait_cycles(0)) dut0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .csr_a(csr_a), .csr_we(csr_we),
      .csr_di(csr_di), .csr_do(csr_do0), .fml(if0));
   fml_bram_target #(.csr_addr(5'h1), .fml_depth(26), .burst_bits(BB1), .wait_cycles(3)) dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .csr_a(csr_a), .csr_we(csr_we),
      .csr_di(csr_di), .csr_do(csr_do1), .fml(if1));

   always #5 sys_clk = ~sys_clk;

   int errors = 0;
   int checks = 0;

   // Reference model: memory as word-indexed arrays, counters as plain integers.
   logic [63:0] m0 [int];
   logic [63:0] m1 [int];
   int          rc [2];
   int          wc [2];
   bit          wp [2];

   // Scoreboard: one kind entry per burst (1 = read), four data words per read.
   bit          kq [2][$];
   logic [63:0] wq [2][$];
   int          bl [2];
   bit          rd_on [2];

   logic [63:0] tdat [4];
   logic [7:0]  tsel [4];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endfunction

   function automatic void fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endfunction

   function automatic int widx(input int d, input logic [25:0] a, input int k);
      int bb;
      bb = (d != 0) ? BB1 : BB0;
      return ((int'(a) >> 5) % (1 << bb)) * 4 + k;
   endfunction

   function automatic logic [63:0] mget(input int d, input int key);
      if (d != 0) return m1.exists(key) ? m1[key] : 64'd0;
      return m0.exists(key) ? m0[key] : 64'd0;
   endfunction

   function automatic void mwrite(input int d, input int key, input logic [63:0] v, input logic [7:0] s);
      logic [63:0] w;
      w = mget(d, key);
      for (int b = 0; b < 8; b++) if (s[b]) w[b*8 +: 8] = v[b*8 +: 8];
      if (d != 0) m1[key] = w; else m0[key] = w;
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         rc[d] = 0;
         wc[d] = 0;
         wp[d] = 1'b0;
      end
   endfunction

   always @(negedge sys_clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!sys_rst_n) begin
            bl[d] = 0;
         end else begin
            if (ack_w[d]) begin
               if (bl[d] != 0) chk($sformatf("ack_beat0_only_d%0d", d), 64'(bl[d]), 64'd0);
               if (kq[d].size() == 0) fail($sformatf("unexpected_ack_d%0d", d));
               else begin
                  rd_on[d] = kq[d].pop_front();
                  bl[d]    = 4;
               end
            end
            if (bl[d] > 0) begin
               if (rd_on[d]) begin
                  if (wq[d].size() == 0) fail($sformatf("rd_data_missing_d%0d", d));
                  else chk($sformatf("rd_data_d%0d_beat%0d", d, 4 - bl[d]), di_w[d], wq[d].pop_front());
               end
               bl[d]--;
            end
         end
      end
   end

   task automatic burst(input int d, input logic [25:0] a, input bit w, input int exp_lat,
                        input bit clr_wc, input int abort_beat);
      int lat;
      bit got;
      kq[d].push_back(!w);
      if (!w) for (int k = 0; k < 4; k++) wq[d].push_back(mget(d, widx(d, a, k)));
      @(posedge sys_clk); #1;
      adr = a; we = w; wdat = tdat[0]; sel = tsel[0]; stb[d] = 1'b1;
      @(posedge sys_clk); #1;
      stb[d] = 1'b0;
      adr = 26'($urandom);
      we  = 1'($urandom);
      lat = 1;
      got = 1'b0;
      while (!got && lat <= 20) begin
         if (ack_w[d]) got = 1'b1;
         else begin
            @(posedge sys_clk); #1;
            lat++;
         end
      end
      chk($sformatf("ack_latency_d%0d", d), 64'(lat), 64'(exp_lat));
      if (!got) return;
      if (clr_wc) begin
         csr_a = {5'(d), 7'd0, 3'd1}; csr_we = 1'b1; csr_di = 32'($urandom);
         wc[d] = 0;
      end else if (w) wc[d]++;
      else rc[d]++;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(posedge sys_clk); #1;
            csr_we = 1'b0;
            wdat = tdat[k]; sel = tsel[k];
         end
         if (k == abort_beat) begin
            #2 sys_rst_n = 1'b0;
            #1;
            chk("ack_in_reset", 64'(ack_w[d]), 64'd0);
            chk("di_in_reset", di_w[d], 64'd0);
            chk("csr_do_in_reset", 64'(csr_do0), 64'd0);
            model_reset();
            @(negedge sys_clk); @(negedge sys_clk);
            sys_rst_n = 1'b1;
            return;
         end
         if (w && !wp[d]) mwrite(d, widx(d, a, k), tdat[k], tsel[k]);
      end
   endtask

   task automatic csr_wr(input int bank, input int off, input logic [31:0] v);
      @(posedge sys_clk); #1;
      csr_a = {5'(bank), 7'd0, 3'(off)}; csr_we = 1'b1; csr_di = v;
      @(posedge sys_clk); #1;
      csr_we = 1'b0;
   endtask

   task automatic csr_rd(input int bank, input int off, input logic [31:0] exp, input string name);
      @(posedge sys_clk); #1;
      csr_a = {5'(bank), 7'd0, 3'(off)}; csr_we = 1'b0;
      @(posedge sys_clk); #1;
      chk(name, 64'((bank != 0) ? csr_do1 : csr_do0), 64'(exp));
      chk({name, "_other_bank"}, 64'((bank != 0) ? csr_do0 : csr_do1), 64'd0);
   endtask

   task automatic fill(input logic [63:0] base, input logic [7:0] s);
      for (int k = 0; k < 4; k++) begin
         tdat[k] = base * 64'(k + 1);
         tsel[k] = s;
      end
   endtask

   task automatic fill_rand();
      for (int k = 0; k < 4; k++) begin
         tdat[k] = {$urandom, $urandom};
         tsel[k] = 8'($urandom);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int t [3];
      int cyc;
      int acks;
      model_reset();
      bl[0] = 0; bl[1] = 0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_ack0", 64'(ack_w[0]), 64'd0);
      chk("rst_di0", di_w[0], 64'd0);
      chk("rst_csr_do0", 64'(csr_do0), 64'd0);
      chk("rst_ack1", 64'(ack_w[1]), 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      csr_rd(0, 0, 32'd0, "rst_read_count");
      csr_rd(0, 2, 32'd0, "rst_wp");

      fill(64'h1111, 8'hFF);
      burst(0, 26'h40, 1'b1, 1, 1'b0, -1);
      burst(0, 26'h40, 1'b0, 1, 1'b0, -1);

      for (int k = 0; k < 4; k++) begin tdat[k] = '1; tsel[k] = 8'h0F; end
      burst(0, 26'h40, 1'b1, 1, 1'b0, -1);
      burst(0, 26'h40, 1'b0, 1, 1'b0, -1);

      fill(64'h0123_4567_89AB_CDEF, 8'hFF);
      burst(0, 26'h40 + 26'(1 << (BB0 + 5)), 1'b1, 1, 1'b0, -1);
      burst(0, 26'h40, 1'b0, 1, 1'b0, -1);

      for (int i = 0; i < 8; i++) begin
         fill_rand();
         for (int k = 0; k < 4; k++) tsel[k] = 8'hFF;
         burst(0, 26'(i << 5), 1'b1, 1, 1'b0, -1);
      end
      for (int i = 0; i < 14; i++) begin
         logic [25:0] ra;
         fill_rand();
         ra = {5'($urandom), 16'd0, 5'($urandom)};
         ra[BB0+4:5] = 10'($urandom_range(0, 7));
         burst(0, ra, 1'($urandom), 1, 1'b0, -1);
      end
      csr_rd(0, 0, 32'(rc[0]), "read_count_d0");
      csr_rd(0, 1, 32'(wc[0]), "write_count_d0");
      csr_rd(0, 5, 32'd0, "unused_offset");

      fill(64'hA5A5_0000_0000_5A5A, 8'hFF);
      burst(1, 26'h40, 1'b1, 4, 1'b0, -1);
      for (int n = 0; n < 3; n++) begin
         kq[1].push_back(1'b1);
         for (int k = 0; k < 4; k++) wq[1].push_back(mget(1, widx(1, 26'h40, k)));
      end
      @(posedge sys_clk); #1;
      adr = 26'h40; we = 1'b0; stb[1] = 1'b1;
      @(posedge sys_clk); #1;
      cyc = 1; acks = 0;
      t[0] = 0; t[1] = 0; t[2] = 0;
      while (acks < 3 && cyc < 100) begin
         if (ack_w[1]) begin
            t[acks] = cyc;
            acks++;
         end
         if (acks < 3) begin
            @(posedge sys_clk); #1;
            cyc++;
         end
      end
      stb[1] = 1'b0;
      rc[1] += acks;
      chk("hold_first_ack", 64'(t[0]), 64'd4);
      chk("hold_spacing_1", 64'(t[1] - t[0]), 64'd8);
      chk("hold_spacing_2", 64'(t[2] - t[1]), 64'd8);
      repeat (4) @(posedge sys_clk);
      csr_rd(1, 0, 32'(rc[1]), "read_count_d1");

      csr_wr(0, 2, 32'h1);
      wp[0] = 1'b1;
      csr_rd(0, 2, 32'h1, "wp_readback");
      fill(64'hDEAD, 8'hFF);
      burst(0, 26'h40, 1'b1, 1, 1'b1, -1);
      csr_rd(0, 1, 32'(wc[0]), "wc_clear_wins");
      burst(0, 26'h40, 1'b1, 1, 1'b0, -1);
      csr_rd(0, 1, 32'(wc[0]), "wc_counts_protected");
      burst(0, 26'h40, 1'b0, 1, 1'b0, -1);
      csr_wr(0, 2, 32'h0);
      wp[0] = 1'b0;
      csr_wr(0, 0, 32'hFFFF_FFFF);
      rc[0] = 0;
      csr_rd(0, 0, 32'd0, "rc_cleared");

      fill(64'h7777_0000_0000_0007, 8'hFF);
      burst(0, 26'h40, 1'b1, 1, 1'b0, 2);
      burst(0, 26'h40, 1'b0, 1, 1'b0, -1);
      csr_rd(0, 0, 32'(rc[0]), "rc_after_reset");
      csr_rd(0, 1, 32'(wc[0]), "wc_after_reset");

      repeat (10) @(posedge sys_clk);
      #1;
      chk("sb_drain_kind", 64'(kq[0].size() + kq[1].size()), 64'd0);
      chk("sb_drain_data", 64'(wq[0].size() + wq[1].size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
